move_detector: RTL and testbench

- Downstream consumer of the matrix scanner's 64-bit sensor_state. It debounces complete scan frames, tracks a committed reference board, and runs a lift/place state machine.
- Emits chess moves as from/to square pairs with a capture flag, over a valid/ready handshake toward the game-logic stage.
- Square index = row*8+col, identical to the sensor_state bit order.

---
 rtl/chess_pkg.sv | 57 +++++
 rtl/frame_debouncer.sv | 61 ++++++
 rtl/move_detector.sv | 191 +++++++++++++++++++
 tb/tb_move_detector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// -----------------------------------------------------------------------------
// chess_pkg
// Shared definitions for the board-sensing pipeline.
//   - state_t       : move-detector FSM states (3-bit encoding, exposed for debug)
//   - SQ_W/BOARD_W  : square index width and board bitmap width
//   - INITIAL_BOARD : occupancy of a standard starting position
//   - square_index  : row/col to square number (row*8+col)
//   - square_bit    : one-hot board mask for a square
//   - is_single     : true when exactly one bit of a board mask is set
//   - lowest_square : index of the lowest set bit of a board mask
// -----------------------------------------------------------------------------
package chess_pkg;

    localparam int SQ_W    = 6;
    localparam int BOARD_W = 64;

    localparam logic [BOARD_W-1:0] INITIAL_BOARD = 64'hFFFF_0000_0000_FFFF;

    typedef logic [SQ_W-1:0]    square_t;
    typedef logic [BOARD_W-1:0] board_t;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        LIFT1 = 3'd2,
        LIFT2 = 3'd3,
        ERROR = 3'd4
    } state_t;

    function automatic square_t square_index(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

    function automatic board_t square_bit(input square_t sq);
        board_t b;
        b     = '0;
        b[sq] = 1'b1;
        return b;
    endfunction

    function automatic logic is_single(input board_t b);
        return (b != '0) && ((b & (b - board_t'(1))) == '0);
    endfunction

    // Scans from the top so the last hit is the lowest set bit.
    function automatic square_t lowest_square(input board_t b);
        square_t sq;
        sq = '0;
        for (int i = BOARD_W - 1; i >= 0; i--) begin
            if (b[i]) begin
                sq = square_index(3'(i / 8), 3'(i % 8));
            end
        end
        return sq;
    endfunction

endpackage

// File: rtl/frame_debouncer.sv
// -----------------------------------------------------------------------------
// frame_debouncer
// Accepts a scan frame as the debounced board once STABLE_FRAMES consecutive
// identical frames have been seen, and pulses d_update once per stable board.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   sensor_state    : raw occupancy bitmap, sampled when frame_valid=1
//   frame_valid     : one-cycle pulse marking a complete scan frame
//   board           : debounced board (D)
//   d_update        : one-cycle pulse, board has just been (re)loaded
// -----------------------------------------------------------------------------
module frame_debouncer
    import chess_pkg::*;
#(
    parameter int STABLE_FRAMES = 4,
    parameter int CNT_W         = $clog2(STABLE_FRAMES + 1)
) (
    input  logic   clk,
    input  logic   rst_n,
    input  board_t sensor_state,
    input  logic   frame_valid,
    output board_t board,
    output logic   d_update
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_FRAMES - 2);

    board_t           last_sample;
    logic [CNT_W-1:0] cnt;

    // The counter counts matches after the first sample of a run, so it
    // reaches CNT_MAX on the STABLE_FRAMES-th identical frame. Firing on the
    // transition into CNT_MAX (not while sitting there) yields exactly one
    // pulse per stable run; only a mismatch can bring the counter back down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sample <= '0;
            cnt         <= '0;
            board       <= '0;
            d_update    <= 1'b0;
        end else begin
            d_update <= 1'b0;
            if (frame_valid) begin
                if (sensor_state == last_sample) begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (cnt == CNT_FIRE) begin
                        board    <= last_sample;
                        d_update <= 1'b1;
                    end
                end else begin
                    last_sample <= sensor_state;
                    cnt         <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/move_detector.sv
// -----------------------------------------------------------------------------
// move_detector
// Turns debounced board snapshots into chess moves. A reference board (R) holds
// the last committed position; a lift/place FSM compares each new debounced
// board (D) against R and emits from/to/capture records downstream.
// Handshake: a record is presented with move_valid=1 and held stable until a
// cycle where move_valid && move_ready; it is consumed on that edge and
// move_valid drops the following cycle unless a new record replaces it.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   sensor_state    : raw occupancy (1 = piece present)
//   frame_valid     : one-cycle pulse per complete scan frame
//   resync          : one-cycle pulse, adopt D as R and return to IDLE
//   move_ready      : downstream can accept a record
//   move_valid      : record valid
//   move_from/to    : origin / destination square (row*8+col)
//   move_capture    : destination was occupied before the move
//   move_error      : FSM is in ERROR
//   ref_board       : committed reference board R
//   fsm_state       : encoded FSM state for debug
// -----------------------------------------------------------------------------
module move_detector
    import chess_pkg::*;
#(
    parameter int STABLE_FRAMES = 4,
    parameter int CNT_W         = $clog2(STABLE_FRAMES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BOARD_W-1:0] sensor_state,
    input  logic               frame_valid,
    input  logic               resync,
    input  logic               move_ready,
    output logic               move_valid,
    output logic [SQ_W-1:0]    move_from,
    output logic [SQ_W-1:0]    move_to,
    output logic               move_capture,
    output logic               move_error,
    output logic [BOARD_W-1:0] ref_board,
    output logic [2:0]         fsm_state
);

    board_t  deb_board;
    logic    d_update;

    state_t  state_q, state_d;
    board_t  ref_q, ref_d;
    square_t sq_a_q, sq_a_d;
    square_t sq_b_q, sq_b_d;

    board_t  removed, added;
    board_t  bit_a, bit_b;
    logic    stalled;
    logic    emit;
    square_t emit_from, emit_to;
    logic    emit_cap;

    frame_debouncer #(
        .STABLE_FRAMES (STABLE_FRAMES),
        .CNT_W         (CNT_W)
    ) u_debouncer (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor_state (sensor_state),
        .frame_valid  (frame_valid),
        .board        (deb_board),
        .d_update     (d_update)
    );

    // Next-state and emit decision. Board relations are expressed through the
    // squares that left R (removed) and appeared outside R (added).
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        sq_a_d    = sq_a_q;
        sq_b_d    = sq_b_q;
        emit      = 1'b0;
        emit_from = '0;
        emit_to   = '0;
        emit_cap  = 1'b0;
        removed   = ref_q & ~deb_board;
        added     = deb_board & ~ref_q;
        bit_a     = square_bit(sq_a_q);
        bit_b     = square_bit(sq_b_q);
        stalled   = move_valid && !move_ready;

        if (resync && state_q != INIT) begin
            ref_d   = deb_board;
            state_d = IDLE;
        end else if (d_update) begin
            unique case (state_q)
                INIT: begin
                    ref_d   = deb_board;
                    state_d = IDLE;
                end
                IDLE: begin
                    if (deb_board == ref_q) begin
                        state_d = IDLE;
                    end else if (added == '0 && is_single(removed)) begin
                        sq_a_d  = lowest_square(removed);
                        state_d = LIFT1;
                    end else begin
                        state_d = ERROR;
                    end
                end
                LIFT1: begin
                    if (deb_board == ref_q) begin
                        state_d = IDLE;
                    end else if (removed == bit_a && is_single(added)) begin
                        emit      = 1'b1;
                        emit_from = sq_a_q;
                        emit_to   = lowest_square(added);
                    end else if (added == '0 && removed[sq_a_q]
                                 && is_single(removed & ~bit_a)) begin
                        sq_b_d  = lowest_square(removed & ~bit_a);
                        state_d = LIFT2;
                    end else begin
                        state_d = ERROR;
                    end
                end
                LIFT2: begin
                    // The square that is occupied again holds the capturing piece.
                    if (added == '0 && removed == bit_a) begin
                        emit      = 1'b1;
                        emit_from = sq_a_q;
                        emit_to   = sq_b_q;
                        emit_cap  = 1'b1;
                    end else if (added == '0 && removed == bit_b) begin
                        emit      = 1'b1;
                        emit_from = sq_b_q;
                        emit_to   = sq_a_q;
                        emit_cap  = 1'b1;
                    end else if (deb_board == ref_q) begin
                        state_d = IDLE;
                    end else if (added == '0 && removed == (bit_a | bit_b)) begin
                        state_d = LIFT2;
                    end else begin
                        state_d = ERROR;
                    end
                end
                ERROR: begin
                    if (deb_board == ref_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = INIT;
            endcase

            // A blocked emit leaves state and R untouched so the same
            // transition is re-tried on the next d_update.
            if (emit && !stalled) begin
                ref_d   = deb_board;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            ref_q        <= '0;
            sq_a_q       <= '0;
            sq_b_q       <= '0;
            move_valid   <= 1'b0;
            move_from    <= '0;
            move_to      <= '0;
            move_capture <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            sq_a_q  <= sq_a_d;
            sq_b_q  <= sq_b_d;
            if (emit && !stalled) begin
                move_valid   <= 1'b1;
                move_from    <= emit_from;
                move_to      <= emit_to;
                move_capture <= emit_cap;
            end else if (move_valid && move_ready) begin
                move_valid   <= 1'b0;
                move_from    <= '0;
                move_to      <= '0;
                move_capture <= 1'b0;
            end
        end
    end

    assign move_error = (state_q == ERROR);
    assign ref_board  = ref_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_move_detector.sv
// -----------------------------------------------------------------------------
// tb_move_detector
// Directed bench for move_detector: scan frames are driven as stable runs,
// expected move records are queued when a move is completed and compared when
// the DUT hands a record over (move_valid && move_ready).
// -----------------------------------------------------------------------------
module tb_move_detector;
    import chess_pkg::*;

    localparam int STABLE_FRAMES = 4;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    board_t sensor_state = '0;
    logic   frame_valid = 1'b0;
    logic   resync = 1'b0;
    logic   move_ready = 1'b0;

    logic               move_valid;
    logic [SQ_W-1:0]    move_from;
    logic [SQ_W-1:0]    move_to;
    logic               move_capture;
    logic               move_error;
    logic [BOARD_W-1:0] ref_board;
    logic [2:0]         fsm_state;

    always #5 clk = ~clk;

    move_detector #(
        .STABLE_FRAMES (STABLE_FRAMES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor_state (sensor_state),
        .frame_valid  (frame_valid),
        .resync       (resync),
        .move_ready   (move_ready),
        .move_valid   (move_valid),
        .move_from    (move_from),
        .move_to      (move_to),
        .move_capture (move_capture),
        .move_error   (move_error),
        .ref_board    (ref_board),
        .fsm_state    (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [12:0] exp_q[$];

    function automatic logic [12:0] rec(input int from, input int to, input logic cap);
        return {6'(from), 6'(to), cap};
    endfunction

    function automatic board_t sqb(input int sq);
        return square_bit(square_t'(sq));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; a handshake is judged at the falling edge before the rising
    // edge that consumes it. Inputs change 1 time unit after the rising edge.
    task automatic tick();
        logic [12:0] exp_rec;
        @(negedge clk);
        if (move_valid && move_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_move observed=%0h expected=none",
                       {move_from, move_to, move_capture});
            end
            if (exp_q.size() != 0) begin
                exp_rec = exp_q.pop_front();
                check("move_record", 64'({move_from, move_to, move_capture}), 64'(exp_rec));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic frame(input board_t b);
        sensor_state = b;
        frame_valid  = 1'b1;
        tick();
        frame_valid  = 1'b0;
        tick();
    endtask

    task automatic stable(input board_t b);
        repeat (STABLE_FRAMES) frame(b);
        tick();
        tick();
    endtask

    task automatic pulse_resync();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        board_t b0, be, b1, b2, b3, b4, b5;
        b0 = INITIAL_BOARD;

        // Reset
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_ref_board", ref_board, 64'h0);
        check("rst_fsm_state", 64'(fsm_state), 64'(INIT));
        check("rst_move_valid", 64'(move_valid), 64'h0);
        check("rst_move_error", 64'(move_error), 64'h0);
        rst_n = 1'b1;
        move_ready = 1'b1;
        tick();

        // Initial board adoption
        stable(b0);
        check("init_ref_board", ref_board, b0);
        check("init_fsm_state", 64'(fsm_state), 64'(IDLE));
        check("init_move_valid", 64'(move_valid), 64'h0);

        // Bounce: alternating frames never debounce
        for (int i = 0; i < 10; i++) begin
            frame((i % 2 == 0) ? (b0 ^ sqb(12)) : b0);
        end
        tick();
        check("bounce_fsm_state", 64'(fsm_state), 64'(IDLE));
        check("bounce_ref_board", ref_board, b0);

        // Put-back: lift and restore without a move
        stable(b0 & ~sqb(12));
        check("putback_lift_state", 64'(fsm_state), 64'(LIFT1));
        stable(b0);
        check("putback_fsm_state", 64'(fsm_state), 64'(IDLE));
        check("putback_ref_board", ref_board, b0);

        // Error: two lifts then a placement elsewhere
        stable(b0 & ~sqb(12));
        stable(b0 & ~sqb(12) & ~sqb(13));
        check("err_lift2_state", 64'(fsm_state), 64'(LIFT2));
        be = (b0 & ~sqb(12) & ~sqb(13)) | sqb(20);
        stable(be);
        check("err_fsm_state", 64'(fsm_state), 64'(ERROR));
        check("err_move_error", 64'(move_error), 64'h1);
        pulse_resync();
        check("resync_fsm_state", 64'(fsm_state), 64'(IDLE));
        check("resync_ref_board", ref_board, be);
        check("resync_move_error", 64'(move_error), 64'h0);
        stable(b0);
        check("restore_err_state", 64'(fsm_state), 64'(ERROR));
        pulse_resync();
        check("restore_ref_board", ref_board, b0);

        // Quiet move 12->28, held while move_ready=0
        move_ready = 1'b0;
        b1 = (b0 & ~sqb(12)) | sqb(28);
        stable(b0 & ~sqb(12));
        exp_q.push_back(rec(12, 28, 1'b0));
        stable(b1);
        check("quiet_move_valid", 64'(move_valid), 64'h1);
        check("quiet_ref_board", ref_board, b1);
        check("quiet_fsm_state", 64'(fsm_state), 64'(IDLE));
        repeat (4) tick();
        check("quiet_hold_valid", 64'(move_valid), 64'h1);
        check("quiet_hold_from", 64'(move_from), 64'd12);
        check("quiet_hold_to", 64'(move_to), 64'd28);
        check("quiet_hold_cap", 64'(move_capture), 64'h0);
        move_ready = 1'b1;
        tick();
        check("quiet_cleared", 64'(move_valid), 64'h0);

        // Back to the starting position
        stable(b0);
        pulse_resync();
        check("restore2_ref_board", ref_board, b0);

        // Capture 12x51, capturing piece lifted first
        b2 = b0 & ~sqb(12);
        stable(b2);
        stable(b2 & ~sqb(51));
        check("cap_lift2_state", 64'(fsm_state), 64'(LIFT2));
        exp_q.push_back(rec(12, 51, 1'b1));
        stable(b2);
        check("cap_ref_board", ref_board, b2);
        check("cap_fsm_state", 64'(fsm_state), 64'(IDLE));
        check("cap_consumed", 64'(move_valid), 64'h0);

        // Capture 13x52, captured piece lifted first
        b3 = b2 & ~sqb(13);
        stable(b2 & ~sqb(52));
        stable(b2 & ~sqb(52) & ~sqb(13));
        exp_q.push_back(rec(13, 52, 1'b1));
        stable(b3);
        check("rcap_ref_board", ref_board, b3);

        // Backpressure: second move deferred until the first is accepted
        move_ready = 1'b0;
        b4 = (b3 & ~sqb(8)) | sqb(24);
        stable(b3 & ~sqb(8));
        exp_q.push_back(rec(8, 24, 1'b0));
        stable(b4);
        check("bp_first_valid", 64'(move_valid), 64'h1);
        b5 = (b4 & ~sqb(9)) | sqb(25);
        stable(b4 & ~sqb(9));
        exp_q.push_back(rec(9, 25, 1'b0));
        stable(b5);
        check("bp_deferred_state", 64'(fsm_state), 64'(LIFT1));
        check("bp_deferred_ref", ref_board, b4);
        check("bp_held_from", 64'(move_from), 64'd8);
        move_ready = 1'b1;
        tick();
        check("bp_first_cleared", 64'(move_valid), 64'h0);
        check("bp_still_lift1", 64'(fsm_state), 64'(LIFT1));
        frame(b5 ^ sqb(0));
        stable(b5);
        check("bp_second_state", 64'(fsm_state), 64'(IDLE));
        check("bp_second_ref", ref_board, b5);

        repeat (4) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
